axis_meta_rr_arbiter: RTL and testbench



---
 rtl/axis_meta_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_axis_meta_rr_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_meta_rr_arbiter.sv
// Round-robin arbiter merging N_REQ metadata streams onto one registered output beat.
// Define AXIS_META_RR_ARBITER_STATS_EN to add per-requester handshake counters (grant_cnt, stats_clr).
module axis_meta_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [N_REQ-1:0]           s_meta_valid,
    output logic [N_REQ-1:0]           s_meta_ready,
    input  logic [N_REQ*WIDTH-1:0]     s_meta_data,
    output logic                       m_meta_valid,
    input  logic                       m_meta_ready,
    output logic [WIDTH-1:0]           m_meta_data,
    output logic [$clog2(N_REQ)-1:0]   m_meta_src
`ifdef AXIS_META_RR_ARBITER_STATS_EN
    ,
    input  logic                       stats_clr,
    output logic [N_REQ*32-1:0]        grant_cnt
`endif
);

    localparam int SRC_W = $clog2(N_REQ);

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q,  out_data_d;
    logic [SRC_W-1:0]     out_src_q,   out_src_d;
    logic [SRC_W-1:0]     last_q,      last_d;

    logic                 load;
    logic                 any_valid;
    logic [SRC_W-1:0]     grant_idx;
    logic [SRC_W:0]       cand;
    logic [N_REQ-1:0]     grant;
    logic [WIDTH-1:0]     req_data [N_REQ];

    // The output register may take a new beat when empty or being drained this cycle.
    assign load = !out_valid_q || m_meta_ready;

    // Scan from the slot after the last grant, wrapping, so the last winner is tried last.
    always_comb begin
        any_valid = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_q} + (SRC_W+1)'(k);
            if (cand >= (SRC_W+1)'(N_REQ)) begin
                cand = cand - (SRC_W+1)'(N_REQ);
            end
            if (!any_valid && s_meta_valid[cand[SRC_W-1:0]]) begin
                any_valid = 1'b1;
                grant_idx = cand[SRC_W-1:0];
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign req_data[gi]     = s_meta_data[gi*WIDTH +: WIDTH];
        assign grant[gi]        = any_valid && (grant_idx == SRC_W'(gi));
        assign s_meta_ready[gi] = load && grant[gi];
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        last_d      = last_q;
        if (load) begin
            out_valid_d = any_valid;
            if (any_valid) begin
                out_data_d = req_data[grant_idx];
                out_src_d  = grant_idx;
                last_d     = grant_idx;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            last_q      <= SRC_W'(N_REQ-1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            last_q      <= last_d;
        end
    end

    assign m_meta_valid = out_valid_q;
    assign m_meta_data  = out_data_q;
    assign m_meta_src   = out_src_q;

`ifdef AXIS_META_RR_ARBITER_STATS_EN
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
        logic [31:0] cnt_q, cnt_d;

        // A clear in the same cycle as a handshake leaves the counter at zero.
        always_comb begin
            cnt_d = cnt_q;
            if (stats_clr) begin
                cnt_d = '0;
            end else if (s_meta_valid[gi] && s_meta_ready[gi]) begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign grant_cnt[gi*32 +: 32] = cnt_q;
    end
`endif

    a_ready_onehot: assert property (@(posedge aclk) disable iff (!aresetn)
        $onehot0(s_meta_ready));

    a_out_stable: assert property (@(posedge aclk) disable iff (!aresetn)
        (m_meta_valid && !m_meta_ready) |=>
            (m_meta_valid && $stable(m_meta_data) && $stable(m_meta_src)));

endmodule

// File: tb/tb_axis_meta_rr_arbiter.sv
// Self-checking bench for axis_meta_rr_arbiter: vector table, directed corner sequences and a
// random-traffic reference model. Counter checks are built when AXIS_META_RR_ARBITER_STATS_EN is defined.
module tb_axis_meta_rr_arbiter;
    localparam int WIDTH = 32;
    localparam int N_REQ = 4;
    localparam int SRC_W = 2;

    logic                   aclk = 1'b0;
    logic                   aresetn;
    logic [N_REQ-1:0]       s_meta_valid;
    logic [N_REQ-1:0]       s_meta_ready;
    logic [N_REQ*WIDTH-1:0] s_meta_data;
    logic                   m_meta_valid;
    logic                   m_meta_ready;
    logic [WIDTH-1:0]       m_meta_data;
    logic [SRC_W-1:0]       m_meta_src;
`ifdef AXIS_META_RR_ARBITER_STATS_EN
    logic                   stats_clr;
    logic [N_REQ*32-1:0]    grant_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int          m_last;
    logic        m_ov;
    logic [31:0] m_od;
    int          m_os;
    int          m_cnt [N_REQ];
    int          hs;

    typedef struct packed {
        logic [3:0] valid;
        logic       mr;
        logic [3:0] ready;
        logic       mv;
        logic [1:0] src;
    } vec_t;
    vec_t tbl [13];

    axis_meta_rr_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_meta_valid (s_meta_valid),
        .s_meta_ready (s_meta_ready),
        .s_meta_data  (s_meta_data),
        .m_meta_valid (m_meta_valid),
        .m_meta_ready (m_meta_ready),
        .m_meta_data  (m_meta_data),
        .m_meta_src   (m_meta_src)
`ifdef AXIS_META_RR_ARBITER_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .grant_cnt    (grant_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic set_data(input int i, input logic [31:0] d);
        s_meta_data[i*WIDTH +: WIDTH] = d;
    endtask

    function automatic int ref_grant(input logic [N_REQ-1:0] v);
        for (int k = 1; k <= N_REQ; k++) begin
            if (v[(m_last + k) % N_REQ]) return (m_last + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last = N_REQ - 1;
        m_ov   = 1'b0;
        m_od   = '0;
        m_os   = 0;
        hs     = 0;
        for (int i = 0; i < N_REQ; i++) m_cnt[i] = 0;
    endtask

    // Resets DUT and model; returns one time unit after a rising edge.
    task automatic do_reset();
        s_meta_valid = '0;
        m_meta_ready = 1'b0;
        aresetn      = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        model_reset();
    endtask

    task automatic fill_data_1000();
        for (int i = 0; i < N_REQ; i++) set_data(i, 32'h1000 + 32'(i));
    endtask

    // One clock of random traffic checked against the reference model.
    task automatic cycle_model();
        logic             load;
        int               g;
        logic [N_REQ-1:0] er;
        load = !m_ov || m_meta_ready;
        g    = ref_grant(s_meta_valid);
        er   = (load && g >= 0) ? (N_REQ'(1) << g) : '0;
        #1;
        chk("rand_ready", 64'(s_meta_ready), 64'(er));
        @(posedge aclk);
        if (load) begin
            m_ov = (g >= 0);
            if (g >= 0) begin
                m_od = s_meta_data[g*WIDTH +: WIDTH];
                m_os = g;
                m_last = g;
                hs++;
                m_cnt[g]++;
            end
        end
        #1;
        if (load && g >= 0) s_meta_valid[g] = 1'b0;
        chk("rand_mvalid", 64'(m_meta_valid), 64'(m_ov));
        if (m_ov) begin
            chk("rand_src", 64'(m_meta_src), 64'(m_os));
            chk("rand_data", 64'(m_meta_data), 64'(m_od));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        aresetn      = 1'b0;
        s_meta_valid = '0;
        s_meta_data  = '0;
        m_meta_ready = 1'b0;
`ifdef AXIS_META_RR_ARBITER_STATS_EN
        stats_clr    = 1'b0;
`endif
        tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[3]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[4]  = '{4'b1010, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[5]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[6]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[8]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
        tbl[9]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[10] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[11] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[12] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};

        // Reset state held for 10 idle cycles
        do_reset();
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("reset_ready", 64'(s_meta_ready), 64'(0));
            chk("reset_mvalid", 64'(m_meta_valid), 64'(0));
            chk("reset_src", 64'(m_meta_src), 64'(0));
            chk("reset_data", 64'(m_meta_data), 64'(0));
            @(posedge aclk);
            #1;
        end

        // Vector table
        do_reset();
        fill_data_1000();
        for (int r = 0; r < 13; r++) begin
            s_meta_valid = tbl[r].valid;
            m_meta_ready = tbl[r].mr;
            #1;
            chk($sformatf("tbl%0d_ready", r), 64'(s_meta_ready), 64'(tbl[r].ready));
            @(posedge aclk);
            #1;
            chk($sformatf("tbl%0d_mvalid", r), 64'(m_meta_valid), 64'(tbl[r].mv));
            if (tbl[r].mv) begin
                chk($sformatf("tbl%0d_src", r), 64'(m_meta_src), 64'(tbl[r].src));
                chk($sformatf("tbl%0d_data", r), 64'(m_meta_data), 64'(32'h1000 + 32'(tbl[r].src)));
            end
        end

        // Fairness: all valid, rotating grants, one beat per cycle
        do_reset();
        fill_data_1000();
        s_meta_valid = 4'b1111;
        m_meta_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge aclk);
            #1;
            chk("rr_mvalid", 64'(m_meta_valid), 64'(1));
            chk("rr_src", 64'(m_meta_src), 64'(c % 4));
            chk("rr_data", 64'(m_meta_data), 64'(32'h1000 + 32'(c % 4)));
        end

        // Single requester 2 streams 8 beats back to back
        do_reset();
        s_meta_valid = 4'b0100;
        set_data(2, 32'hA0);
        m_meta_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("solo_ready", 64'(s_meta_ready), 64'(4'b0100));
            @(posedge aclk);
            #1;
            chk("solo_mvalid", 64'(m_meta_valid), 64'(1));
            chk("solo_src", 64'(m_meta_src), 64'(2));
            chk("solo_data", 64'(m_meta_data), 64'(32'hA0 + 32'(k)));
            if (k < 7) set_data(2, 32'hA1 + 32'(k));
            else s_meta_valid = '0;
        end
        @(posedge aclk);
        #1;
        chk("solo_drain", 64'(m_meta_valid), 64'(0));

        // Output stall holds beat 0x55; pointer then resumes after requester 0
        do_reset();
        set_data(0, 32'h55);
        s_meta_valid = 4'b0001;
        m_meta_ready = 1'b0;
        @(posedge aclk);
        #1;
        chk("stall_load", 64'(m_meta_data), 64'(32'h55));
        s_meta_valid = 4'b1010;
        set_data(1, 32'h1001);
        set_data(3, 32'h1003);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_ready", 64'(s_meta_ready), 64'(0));
            @(posedge aclk);
            #1;
            chk("stall_mvalid", 64'(m_meta_valid), 64'(1));
            chk("stall_data", 64'(m_meta_data), 64'(32'h55));
            chk("stall_src", 64'(m_meta_src), 64'(0));
        end
        m_meta_ready = 1'b1;
        #1;
        chk("resume_ready1", 64'(s_meta_ready), 64'(4'b0010));
        @(posedge aclk);
        #1;
        chk("resume_src1", 64'(m_meta_src), 64'(1));
        chk("resume_data1", 64'(m_meta_data), 64'(32'h1001));
        s_meta_valid = 4'b1000;
        #1;
        chk("resume_ready3", 64'(s_meta_ready), 64'(4'b1000));
        @(posedge aclk);
        #1;
        chk("resume_src3", 64'(m_meta_src), 64'(3));
        chk("resume_data3", 64'(m_meta_data), 64'(32'h1003));

        // Asynchronous reset mid-cycle while a beat is held
        m_meta_ready = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        chk("areset_mvalid", 64'(m_meta_valid), 64'(0));
        chk("areset_src", 64'(m_meta_src), 64'(0));
        fill_data_1000();
        s_meta_valid = 4'b1111;
        m_meta_ready = 1'b1;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        model_reset();
        @(posedge aclk);
        #1;
        chk("areset_first_src", 64'(m_meta_src), 64'(0));
        chk("areset_first_mvalid", 64'(m_meta_valid), 64'(1));

        // Random AXI-legal traffic against the reference model, 100 handshakes
        do_reset();
        cyc = 0;
        while (hs < 100 && cyc < 3000) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!s_meta_valid[i] && ($urandom % 3 == 0)) begin
                    s_meta_valid[i] = 1'b1;
                    set_data(i, $urandom);
                end
            end
            m_meta_ready = ($urandom % 4) != 0;
            cycle_model();
            cyc++;
        end
        s_meta_valid = '0;
        chk("rand_handshakes", 64'(hs), 64'(100));

`ifdef AXIS_META_RR_ARBITER_STATS_EN
        begin
            logic [31:0] sum;
            sum = '0;
            for (int i = 0; i < N_REQ; i++) begin
                sum = sum + grant_cnt[i*32 +: 32];
                chk($sformatf("cnt%0d", i), 64'(grant_cnt[i*32 +: 32]), 64'(m_cnt[i]));
            end
            chk("cnt_sum", 64'(sum), 64'(100));
        end
        // Clear coinciding with a requester 0 handshake
        m_meta_ready = 1'b1;
        s_meta_valid = 4'b0001;
        set_data(0, 32'h77);
        stats_clr = 1'b1;
        #1;
        chk("clr_ready", 64'(s_meta_ready), 64'(4'b0001));
        @(posedge aclk);
        #1;
        stats_clr = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            chk($sformatf("clr_cnt%0d", i), 64'(grant_cnt[i*32 +: 32]), 64'(0));
        end
        set_data(0, 32'h78);
        @(posedge aclk);
        #1;
        s_meta_valid = '0;
        chk("post_clr_cnt0", 64'(grant_cnt[31:0]), 64'(1));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
